// File: rtl/lane_pack_pkg.sv
// Shared types and defaults for the lane packer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lane_pack_pkg;

    // Lane width is fixed by the downstream N-lane consumer.
    localparam int LANE_W = 28;

    // Default number of lanes per packed vector.
    localparam int LANE_N = 4;

    typedef logic [LANE_W-1:0] lane_t;

endpackage : lane_pack_pkg

// File: rtl/lane_pack_oreg.sv
// Purpose: one-entry output register holding a packed vector for the consumer.
// Latency: 1 cycle from load to out_valid.
// Backpressure: holds out_data/out_valid stable while out_ready is low; drain and reload may share a cycle.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   load            a closing word was accepted; capture load_data this cycle
//   load_data       completed vector (lane 0 = first word)
//   load_mask       lanes holding real data (LANE_PACK_LAST_EN only)
//   out_ready       consumer accepts the held vector
//   out_valid       held vector is valid
//   out_data        held vector
//   out_mask        lane-valid mask of the held vector (LANE_PACK_LAST_EN only)
//
// Optional feature macro: LANE_PACK_LAST_EN (adds load_mask/out_mask).
module lane_pack_oreg
    import lane_pack_pkg::*;
#(
    parameter int N = LANE_N,
    parameter int W = LANE_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [N-1:0][W-1:0] load_data,
`ifdef LANE_PACK_LAST_EN
    input  logic [N-1:0]        load_mask,
    output logic [N-1:0]        out_mask,
`endif
    input  logic                out_ready,
    output logic                out_valid,
    output logic [N-1:0][W-1:0] out_data
);

    // A load always wins over a drain: when both happen in the same cycle the
    // old vector leaves and the new one takes its place, so out_valid stays high.
    // out_data is only written on load, which keeps it stable during a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
`ifdef LANE_PACK_LAST_EN
            out_mask  <= '0;
`endif
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
`ifdef LANE_PACK_LAST_EN
            out_mask  <= load_mask;
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule : lane_pack_oreg

// File: rtl/lane_pack.sv
// Purpose: serial-to-parallel packer, N consecutive W-bit words -> one packed [N-1:0][W-1:0] vector.
// Latency: closing word accepted in cycle t -> out_valid in cycle t+1; 1 word/cycle sustained.
// Backpressure: lanes 0..N-2 keep filling while the output is stalled; in_ready drops only on the closing word.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   in_valid/in_ready/in_data   input word stream; k-th word of a vector lands in lane k
//   in_last         close the vector early after this word (LANE_PACK_LAST_EN only)
//   out_valid/out_ready/out_data  packed vector stream, lane 0 = first word
//   out_mask        bit k set when lane k holds real data (LANE_PACK_LAST_EN only)
//
// Optional feature macro: LANE_PACK_LAST_EN (in_last / out_mask, early close with zero-filled lanes).
module lane_pack
    import lane_pack_pkg::*;
#(
    parameter int N = LANE_N,
    parameter int W = LANE_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W-1:0]        in_data,
`ifdef LANE_PACK_LAST_EN
    input  logic                in_last,
    output logic [N-1:0]        out_mask,
`endif
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N-1:0][W-1:0] out_data
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] CNT_MAX = CW'(N - 1);

    // Vector layout matches the consumer's packed lane port.
    typedef lane_t [N-1:0] vec_t;

    vec_t          acc;
    vec_t          load_vec;
    logic [CW-1:0] cnt;
    logic          closing_word;
    logic          xfer;
    logic          close;
`ifdef LANE_PACK_LAST_EN
    logic [N-1:0]  load_mask;
`endif

    // The word on the bus completes the vector if it fills the last lane or
    // (with early close enabled) carries in_last.
`ifdef LANE_PACK_LAST_EN
    assign closing_word = (cnt == CNT_MAX) || in_last;
`else
    assign closing_word = (cnt == CNT_MAX);
`endif

    // Non-closing words only touch the accumulator, so they are always
    // accepted. A closing word needs the output register free, or being
    // drained this very cycle, hence the combinational path from out_ready.
    assign in_ready = !rst && (!closing_word || !out_valid || out_ready);
    assign xfer     = in_valid && in_ready;
    assign close    = xfer && closing_word;

    // Vector as it will look once the current word is merged in. Lanes above
    // cnt are still zero because acc is cleared on every close and reset.
    always_comb begin
        load_vec      = acc;
        load_vec[cnt] = in_data;
    end

`ifdef LANE_PACK_LAST_EN
    // Lanes 0..cnt hold data at close time: (1 << (cnt+1)) - 1.
    always_comb begin
        load_mask = '0;
        for (int k = 0; k < N; k++) begin
            load_mask[k] = (k <= int'(cnt));
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
        end else if (xfer) begin
            if (closing_word) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc[cnt] <= in_data;
                cnt      <= cnt + CW'(1);
            end
        end
    end

    lane_pack_oreg #(
        .N (N),
        .W (W)
    ) u_oreg (
        .clk       (clk),
        .rst       (rst),
        .load      (close),
        .load_data (load_vec),
`ifdef LANE_PACK_LAST_EN
        .load_mask (load_mask),
        .out_mask  (out_mask),
`endif
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

endmodule : lane_pack

// File: tb/tb_lane_pack.sv
// Directed bench for lane_pack with a word-queue reference model and literal spot checks.
module tb_lane_pack;

    localparam int N = 4;
    localparam int W = 28;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [W-1:0]        in_data;
    logic                in_last;
    logic                out_valid;
    logic                out_ready;
    logic [N-1:0][W-1:0] out_data;
`ifdef LANE_PACK_LAST_EN
    logic [N-1:0]        out_mask;
`endif

    always #5 clk = ~clk;

    lane_pack #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
`ifdef LANE_PACK_LAST_EN
        .in_last   (in_last),
        .out_mask  (out_mask),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Words of the vector under construction, plus the one held output vector.
    logic [W-1:0]        cur[$];
    bit                  live  = 0;
    bit                  m_vld = 0;
    logic [N-1:0][W-1:0] m_data = '0;
    logic [N-1:0]        m_mask = '0;
    bit                  m_close;
    int                  cyc = 0;
    int                  hs_cyc[$];

`ifdef LANE_PACK_LAST_EN
    localparam bit LAST_EN = 1'b1;
`else
    localparam bit LAST_EN = 1'b0;
`endif

    function automatic bit last_in();
        return LAST_EN && (in_last === 1'b1);
    endfunction

    // A word may always enter unless it would finish a vector while the
    // output slot is occupied and not being taken.
    function automatic bit model_ready();
        bit finishing;
        finishing = (cur.size() == N - 1) || last_in();
        return !rst && (!finishing || !m_vld || out_ready);
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            live = 1;
            cur.delete();
            m_vld  = 0;
            m_data = '0;
            m_mask = '0;
        end else if (live) begin
            m_close = 0;
            if (in_valid && model_ready()) begin
                cur.push_back(in_data);
                if (cur.size() == N || last_in()) begin
                    m_close = 1;
                    m_data  = '0;
                    m_mask  = '0;
                    for (int k = 0; k < cur.size(); k++) begin
                        m_data[k] = cur[k];
                        m_mask[k] = 1'b1;
                    end
                    cur.delete();
                end
            end
            if (m_close) m_vld = 1;
            else if (out_ready) m_vld = 0;
        end
    end

    // Continuous comparison against the model, away from the clock edge.
    always @(negedge clk) begin
        if (live) begin
            chk("in_ready", {127'b0, in_ready}, {127'b0, model_ready()});
            chk("out_valid", {127'b0, out_valid}, {127'b0, m_vld});
            if (m_vld) begin
                chk("out_data", 128'(out_data), 128'(m_data));
`ifdef LANE_PACK_LAST_EN
                chk("out_mask", 128'(out_mask), 128'(m_mask));
`endif
            end
            if (!rst && out_valid && out_ready) hs_cyc.push_back(cyc);
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [W-1:0] d, input logic last, output int waited);
        bit took;
        waited   = 0;
        took     = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!took && waited < 50) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
            if (!took) waited++;
        end
        if (!took) chk("send_timeout", 128'd0, 128'd1);
        in_last = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int stalls;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_in_ready", {127'b0, in_ready}, 128'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", {127'b0, out_valid}, 128'd0);
        chk("rst_out_data", 128'(out_data), 128'd0);
        chk("post_rst_in_ready", {127'b0, in_ready}, 128'd1);
        @(posedge clk);
        #1;

        // T1: one vector, latency and single-cycle valid
        send(28'h1, 1'b0, w);
        send(28'h2, 1'b0, w);
        send(28'h3, 1'b0, w);
        send(28'h4, 1'b0, w);
        in_valid = 1'b0;
        @(negedge clk);
        chk("t1_valid", {127'b0, out_valid}, 128'd1);
        chk("t1_data", 128'(out_data), 128'({28'h4, 28'h3, 28'h2, 28'h1}));
        chk("t1_model", 128'(m_data), 128'({28'h4, 28'h3, 28'h2, 28'h1}));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t1_valid_drop", {127'b0, out_valid}, 128'd0);
        @(posedge clk);
        #1;

        // T2: 8 back-to-back words, no stalls, vectors 4 cycles apart
        hs_cyc.delete();
        stalls = 0;
        for (int i = 0; i < 8; i++) begin
            send(28'h10 + 28'(i), 1'b0, w);
            stalls += w;
        end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("t2_stalls", 128'(stalls), 128'd0);
        chk("t2_vectors", 128'(hs_cyc.size()), 128'd2);
        if (hs_cyc.size() == 2)
            chk("t2_spacing", 128'(hs_cyc[1] - hs_cyc[0]), 128'd4);

        // T3: backpressure, fill lanes 0..2, stall at lane 3, then drain+load
        send(28'h21, 1'b0, w);
        send(28'h22, 1'b0, w);
        send(28'h23, 1'b0, w);
        send(28'h24, 1'b0, w);
        out_ready = 1'b0;
        send(28'h31, 1'b0, w);
        send(28'h32, 1'b0, w);
        send(28'h33, 1'b0, w);
        chk("t3_fill_stalls", 128'(w), 128'd0);
        in_valid = 1'b1;
        in_data  = 28'h34;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_stall_ready", {127'b0, in_ready}, 128'd0);
            chk("t3_stall_valid", {127'b0, out_valid}, 128'd1);
            chk("t3_stall_data", 128'(out_data), 128'({28'h24, 28'h23, 28'h22, 28'h21}));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("t3_release_ready", {127'b0, in_ready}, 128'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("t3_second_valid", {127'b0, out_valid}, 128'd1);
        chk("t3_second_data", 128'(out_data), 128'({28'h34, 28'h33, 28'h32, 28'h31}));
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;

        // T4: reset mid-vector discards the partial lanes
        send(28'h41, 1'b0, w);
        send(28'h42, 1'b0, w);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t4_valid_after_rst", {127'b0, out_valid}, 128'd0);
        chk("t4_data_after_rst", 128'(out_data), 128'd0);
        @(posedge clk);
        #1;
        hs_cyc.delete();
        send(28'h51, 1'b0, w);
        send(28'h52, 1'b0, w);
        send(28'h53, 1'b0, w);
        send(28'h54, 1'b0, w);
        in_valid = 1'b0;
        @(negedge clk);
        chk("t4_fresh_data", 128'(out_data), 128'({28'h54, 28'h53, 28'h52, 28'h51}));
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("t4_vectors", 128'(hs_cyc.size()), 128'd1);

`ifdef LANE_PACK_LAST_EN
        // T5: early close with in_last, then a full vector from lane 0
        send(28'hA, 1'b0, w);
        send(28'hB, 1'b1, w);
        in_valid = 1'b0;
        @(negedge clk);
        chk("t5_short_data", 128'(out_data), 128'({28'h0, 28'h0, 28'hB, 28'hA}));
        chk("t5_short_mask", 128'(out_mask), 128'h3);
        @(posedge clk);
        #1;
        send(28'hC, 1'b0, w);
        send(28'hD, 1'b0, w);
        send(28'hE, 1'b0, w);
        send(28'hF, 1'b1, w);
        in_valid = 1'b0;
        @(negedge clk);
        chk("t5_full_data", 128'(out_data), 128'({28'hF, 28'hE, 28'hD, 28'hC}));
        chk("t5_full_mask", 128'(out_mask), 128'hF);
        @(posedge clk);
        #1;
`endif

        repeat (3) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_lane_pack
